// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV32I datapath: steps each instruction through
// fetch/decode/execute/memory/writeback, handshakes with memory and flags faults.
module multicycle_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             error
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_ERROR     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [1:0] SRC_B_RS2 = 2'b00;
    localparam logic [1:0] SRC_B_4   = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // The counter only has to reach MEM_TIMEOUT-1: the next not-ready cycle is the timeout.
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               retire;
    logic               is_wait;
    logic               timed_out;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign is_wait   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timed_out = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt_q == TMO_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        error      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_4;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LD, OP_ST: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                // Only ld and st can reach here, so bit 5 alone separates them.
                state_d   = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)      state_d = S_MEM_WB;
                else if (timed_out) state_d = S_ERROR;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_BR;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ERROR: error = 1'b1;
            default: state_d = S_ERROR;
        endcase

        // Clearing whenever the state changes guarantees a fresh count on entry.
        if (!is_wait || (state_d != state_q)) wait_cnt_d = '0;
        else if (!mem_ready)                   wait_cnt_d = wait_cnt_q + 1'b1;
        else                                   wait_cnt_d = wait_cnt_q;

        instr_count_d = retire ? instr_count_q + 1'b1 : instr_count_q;
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks every instruction class, the memory
// wait/timeout boundaries, illegal opcodes and asynchronous reset mid-instruction.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, mem_to_reg, alu_src_a, error;
    logic [1:0]  alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [13:0] ctrl_bus;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
    //  alu_src_a, alu_src_b[1:0], alu_op[1:0], error}
    localparam logic [13:0] C_IDLE       = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] C_FETCH_RDY  = 14'b1_0_1_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] C_FETCH_WAIT = 14'b0_0_0_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] C_DECODE     = 14'b0_0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [13:0] C_MEM_ADDR   = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [13:0] C_MEM_READ   = 14'b0_0_0_1_1_0_0_0_0_00_00_0;
    localparam logic [13:0] C_MEM_WB     = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [13:0] C_MEM_WRITE  = 14'b0_0_0_1_0_1_0_0_0_00_00_0;
    localparam logic [13:0] C_EXEC_R     = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [13:0] C_EXEC_I     = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [13:0] C_ALU_WB     = 14'b0_0_0_0_0_0_1_0_0_00_00_0;
    localparam logic [13:0] C_BR_T       = 14'b1_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] C_BR_NT      = 14'b0_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] C_ERROR      = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

    assign ctrl_bus = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
                       mem_to_reg, alu_src_a, alu_src_b, alu_op, error};

    multicycle_control_fsm #(
        .CNT_W      (32),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state      (state),
        .instr_count(instr_count),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_s(input string tag, input logic [3:0] st, input logic [13:0] ctl,
                            input logic [31:0] cnt);
        #1;
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".ctrl"},  32'(ctrl_bus), 32'(ctl));
        check({tag, ".count"}, instr_count, cnt);
    endtask

    // Asserts reset between clock edges, checks the async clear, releases after an edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        expect_s({tag, "_async"}, 4'd0, C_IDLE, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        expect_s("rst", 4'd0, C_IDLE, 32'd0);
        reset = 1'b0;

        // R-type with memory always ready
        tick(); expect_s("r_fetch",  4'd1, C_FETCH_RDY, 32'd0);
        tick(); expect_s("r_decode", 4'd2, C_DECODE,    32'd0);
        tick(); expect_s("r_exec",   4'd7, C_EXEC_R,    32'd0);
        tick(); expect_s("r_wb",     4'd9, C_ALU_WB,    32'd0);
        tick(); mem_ready = 1'b0; opcode = OP_LD;
        expect_s("ld_fetch_w1", 4'd1, C_FETCH_WAIT, 32'd1);

        // Load: fetch waits 3 cycles then ready on the 4th (ready beats timeout)
        tick(); expect_s("ld_fetch_w2", 4'd1, C_FETCH_WAIT, 32'd1);
        tick(); expect_s("ld_fetch_w3", 4'd1, C_FETCH_WAIT, 32'd1);
        tick(); mem_ready = 1'b1;
        expect_s("ld_fetch_r4", 4'd1, C_FETCH_RDY, 32'd1);
        tick(); expect_s("ld_decode", 4'd2, C_DECODE, 32'd1);
        tick(); mem_ready = 1'b0;
        expect_s("ld_addr", 4'd3, C_MEM_ADDR, 32'd1);
        tick(); expect_s("ld_rd_w1", 4'd4, C_MEM_READ, 32'd1);
        tick(); expect_s("ld_rd_w2", 4'd4, C_MEM_READ, 32'd1);
        tick(); expect_s("ld_rd_w3", 4'd4, C_MEM_READ, 32'd1);
        tick(); mem_ready = 1'b1;
        expect_s("ld_rd_r4", 4'd4, C_MEM_READ, 32'd1);
        tick(); expect_s("ld_wb", 4'd5, C_MEM_WB, 32'd1);
        tick(); opcode = OP_BR; zero = 1'b1;
        expect_s("br_fetch", 4'd1, C_FETCH_RDY, 32'd2);

        // Branch taken, then not taken; both retire
        tick(); expect_s("brt_decode", 4'd2, C_DECODE, 32'd2);
        tick(); expect_s("brt_exec",   4'd10, C_BR_T,  32'd2);
        tick(); zero = 1'b0;
        expect_s("brn_fetch", 4'd1, C_FETCH_RDY, 32'd3);
        tick(); expect_s("brn_decode", 4'd2, C_DECODE, 32'd3);
        tick(); expect_s("brn_exec",   4'd10, C_BR_NT, 32'd3);
        tick(); opcode = OP_I;
        expect_s("i_fetch", 4'd1, C_FETCH_RDY, 32'd4);

        // I-type ALU
        tick(); expect_s("i_decode", 4'd2, C_DECODE, 32'd4);
        tick(); expect_s("i_exec",   4'd8, C_EXEC_I, 32'd4);
        tick(); expect_s("i_wb",     4'd9, C_ALU_WB, 32'd4);
        tick(); opcode = OP_ST;
        expect_s("st_fetch", 4'd1, C_FETCH_RDY, 32'd5);

        // Store completing at once
        tick(); expect_s("st_decode", 4'd2, C_DECODE,    32'd5);
        tick(); expect_s("st_addr",   4'd3, C_MEM_ADDR,  32'd5);
        tick(); expect_s("st_write",  4'd6, C_MEM_WRITE, 32'd5);
        tick(); expect_s("st2_fetch", 4'd1, C_FETCH_RDY, 32'd6);

        // Store interrupted by reset while waiting on memory
        tick(); expect_s("st2_decode", 4'd2, C_DECODE, 32'd6);
        tick(); mem_ready = 1'b0;
        expect_s("st2_addr", 4'd3, C_MEM_ADDR, 32'd6);
        tick(); expect_s("st2_w1", 4'd6, C_MEM_WRITE, 32'd6);
        tick(); expect_s("st2_w2", 4'd6, C_MEM_WRITE, 32'd6);
        do_reset("st2_rst");
        expect_s("st2_rel", 4'd0, C_IDLE, 32'd0);

        // Fetch timeout: 4 not-ready cycles then ERROR
        tick(); expect_s("to_f1", 4'd1, C_FETCH_WAIT, 32'd0);
        tick(); expect_s("to_f2", 4'd1, C_FETCH_WAIT, 32'd0);
        tick(); expect_s("to_f3", 4'd1, C_FETCH_WAIT, 32'd0);
        tick(); expect_s("to_f4", 4'd1, C_FETCH_WAIT, 32'd0);
        tick(); expect_s("to_err", 4'd15, C_ERROR, 32'd0);
        do_reset("to_rst");

        // Load read timeout
        mem_ready = 1'b1; opcode = OP_LD;
        tick(); expect_s("rto_fetch", 4'd1, C_FETCH_RDY, 32'd0);
        tick(); expect_s("rto_decode", 4'd2, C_DECODE, 32'd0);
        tick(); mem_ready = 1'b0;
        expect_s("rto_addr", 4'd3, C_MEM_ADDR, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_s("rto_wait", 4'd4, C_MEM_READ, 32'd0);
        end
        tick(); expect_s("rto_err", 4'd15, C_ERROR, 32'd0);
        do_reset("rto_rst");

        // Illegal opcode: ERROR is sticky for 20 cycles regardless of inputs
        mem_ready = 1'b1; opcode = OP_BAD;
        tick(); expect_s("bad_fetch",  4'd1, C_FETCH_RDY, 32'd0);
        tick(); expect_s("bad_decode", 4'd2, C_DECODE,    32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            mem_ready = i[0];
            zero      = i[1];
            opcode    = OP_R;
            expect_s("bad_hold", 4'd15, C_ERROR, 32'd0);
        end
        do_reset("bad_rst");
        expect_s("bad_rel", 4'd0, C_IDLE, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
